// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_scan_sequencer
//  Purpose  : Channel-scanning controller for the LTC2308 converter interface.
//             Walks an 8-bit channel mask in ascending order. For each enabled
//             channel it raises a conversion request, waits for the converter's
//             done level and stores the 12-bit result in a per-channel bank.
//             The host reads the bank through a registered read port.
//
//  Ports    : clk              - system clock (same domain as converter)
//             reset_n          - synchronous, active-low reset
//             scan_go          - single-cycle scan request
//             scan_continuous  - 1 = restart automatically after each scan
//             ch_mask[7:0]     - channel enables, sampled at scan start
//             busy             - high while a scan is in progress
//             scan_done        - one-cycle pulse at the end of each scan
//             ch_valid[7:0]    - channel result updated in current/last scan
//             timeout_err[7:0] - sticky per-channel timeout flags
//             rd_addr[2:0]     - result bank read address
//             rd_data[11:0]    - result[rd_addr], one cycle latency
//             measure_start    - to converter, rising edge starts conversion
//             measure_ch[2:0]  - to converter, channel select
//             measure_done     - from converter, level, data valid
//             measure_dataread - from converter, conversion result
//
//  Options  : ADC_SCAN_AVG_EN  - when defined, every channel is converted
//                                four times and the truncated mean is stored.
//
//  Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int START_LOW_CYCLES = 2,
    parameter int GUARD_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_go,
    input  logic        scan_continuous,
    input  logic [7:0]  ch_mask,
    output logic        busy,
    output logic        scan_done,
    output logic [7:0]  ch_valid,
    output logic [7:0]  timeout_err,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic        measure_start,
    output logic [2:0]  measure_ch,
    input  logic        measure_done,
    input  logic [11:0] measure_dataread
);

    // ------------------------------------------------------------------------
    // One shared phase counter serves ARM, FIRE and WAIT; size it for the
    // longest of the three intervals.
    // ------------------------------------------------------------------------
    localparam int c_max_a   = (TIMEOUT_CYCLES > START_LOW_CYCLES) ? TIMEOUT_CYCLES
                                                                   : START_LOW_CYCLES;
    localparam int c_max_cnt = (c_max_a > GUARD_CYCLES) ? c_max_a : GUARD_CYCLES;
    localparam int CNT_W     = $clog2(c_max_cnt + 1);

    localparam logic [CNT_W-1:0] c_arm_last   = CNT_W'(START_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_fire_last  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wait_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_ARM   = 3'd2,
        S_FIRE  = 3'd3,
        S_WAIT  = 3'd4,
        S_STORE = 3'd5
    } state_e;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [7:0]        mask_q, mask_d;          // channels still to convert
    logic [2:0]        ch_q, ch_d;              // channel under conversion
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        valid_q, valid_d;
    logic [7:0]        err_q, err_d;
    logic [11:0]       result_q [8];
    logic [11:0]       rd_data_q;

    // Bank write request from the next-state logic
    logic              wr_en;
    logic [11:0]       wr_data;

    // Lowest set bit of the remaining mask
    logic [2:0]        pick_ch;

`ifdef ADC_SCAN_AVG_EN
    logic [1:0]        rep_q, rep_d;            // conversion index 0..3
    logic [13:0]       acc_q, acc_d;            // sum of up to four samples
    logic [13:0]       acc_sum;
`endif

    // ------------------------------------------------------------------------
    // Priority pick: iterate downwards so the lowest set bit wins.
    // ------------------------------------------------------------------------
    always_comb begin
        pick_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                pick_ch = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        wr_data   = measure_dataread;
        scan_done = 1'b0;
`ifdef ADC_SCAN_AVG_EN
        rep_d     = rep_q;
        acc_d     = acc_q;
        acc_sum   = acc_q + {2'b00, measure_dataread};
`endif

        case (state_q)
            S_IDLE: begin
                // An empty mask would produce an empty scan; ignore it.
                if (scan_go && (ch_mask != 8'h00)) begin
                    mask_d  = ch_mask;
                    valid_d = 8'h00;
                    err_d   = 8'h00;
                    state_d = S_PICK;
                end
            end

            S_PICK: begin
                if (mask_q == 8'h00) begin
                    scan_done = 1'b1;
                    // Continuous mode re-latches the live mask so the host can
                    // change the channel set between scans without stopping.
                    if (scan_continuous && (ch_mask != 8'h00)) begin
                        mask_d  = ch_mask;
                        valid_d = 8'h00;
                        err_d   = 8'h00;
                        state_d = S_PICK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ch_d    = pick_ch;
                    cnt_d   = '0;
`ifdef ADC_SCAN_AVG_EN
                    rep_d   = 2'd0;
                    acc_d   = 14'd0;
`endif
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                if (cnt_q == c_arm_last) begin
                    cnt_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    cnt_d   = cnt_q + c_cnt_one;
                end
            end

            S_FIRE: begin
                // Done may still be high from the previous conversion during
                // the first cycles after the start edge, so it is not looked at.
                if (cnt_q == c_fire_last) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d   = cnt_q + c_cnt_one;
                end
            end

            S_WAIT: begin
                if (measure_done) begin
                    cnt_d   = '0;
                    state_d = S_STORE;
                end else if (cnt_q == c_wait_last) begin
                    // Abandon the channel; its stored result is left alone.
                    err_d[ch_q]  = 1'b1;
                    mask_d[ch_q] = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_PICK;
                end else begin
                    cnt_d   = cnt_q + c_cnt_one;
                end
            end

            S_STORE: begin
`ifdef ADC_SCAN_AVG_EN
                if (rep_q == 2'd3) begin
                    // Divide by four by dropping the two LSBs of the sum.
                    wr_en          = 1'b1;
                    wr_data        = acc_sum[13:2];
                    valid_d[ch_q]  = 1'b1;
                    mask_d[ch_q]   = 1'b0;
                    state_d        = S_PICK;
                end else begin
                    acc_d   = acc_sum;
                    rep_d   = rep_q + 2'd1;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
`else
                wr_en          = 1'b1;
                valid_d[ch_q]  = 1'b1;
                mask_d[ch_q]   = 1'b0;
                state_d        = S_PICK;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mask_q  <= 8'h00;
            ch_q    <= 3'd0;
            cnt_q   <= '0;
            valid_q <= 8'h00;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef ADC_SCAN_AVG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_q <= 2'd0;
            acc_q <= 14'd0;
        end else begin
            rep_q <= rep_d;
            acc_q <= acc_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Result bank and registered read port. A read in the same cycle as the
    // write returns the previous contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                result_q[i] <= 12'h000;
            end
            rd_data_q <= 12'h000;
        end else begin
            if (wr_en) begin
                result_q[ch_q] <= wr_data;
            end
            rd_data_q <= result_q[rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy          = (state_q != S_IDLE);
    assign ch_valid      = valid_q;
    assign timeout_err   = err_q;
    assign rd_data       = rd_data_q;
    // Start stays high through WAIT so the converter sees one clean edge.
    assign measure_start = (state_q == S_FIRE) || (state_q == S_WAIT);
    assign measure_ch    = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_scan_sequencer
//  Purpose  : Directed self-checking bench for adc_scan_sequencer with a
//             behavioural LTC2308 converter model and a channel scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    localparam int LAT       = 400;   // converter latency after start edge
    localparam int GUARD     = 2;
    localparam int TIMEOUT   = 1024;
`ifdef ADC_SCAN_AVG_EN
    localparam int N_CONV    = 4;
`else
    localparam int N_CONV    = 1;
`endif
    localparam int BUDGET    = 9000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_go = 1'b0;
    logic        scan_continuous = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        busy;
    logic        scan_done;
    logic [7:0]  ch_valid;
    logic [7:0]  timeout_err;
    logic [2:0]  rd_addr = 3'd0;
    logic [11:0] rd_data;
    logic        measure_start;
    logic [2:0]  measure_ch;
    logic        measure_done = 1'b0;
    logic [11:0] measure_dataread = 12'h000;

    always #5 clk = ~clk;

    adc_scan_sequencer #(
        .TIMEOUT_CYCLES   (TIMEOUT),
        .START_LOW_CYCLES (2),
        .GUARD_CYCLES     (GUARD)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .scan_go          (scan_go),
        .scan_continuous  (scan_continuous),
        .ch_mask          (ch_mask),
        .busy             (busy),
        .scan_done        (scan_done),
        .ch_valid         (ch_valid),
        .timeout_err      (timeout_err),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .measure_start    (measure_start),
        .measure_ch       (measure_ch),
        .measure_done     (measure_done),
        .measure_dataread (measure_dataread)
    );

    // ------------------------------------------------------------------------
    // Converter model: done rises LAT cycles after each start edge and drops
    // when start falls. Data is 0x100+ch, or a 1,2,3,... sequence in avg mode.
    // ------------------------------------------------------------------------
    logic       m_prev = 1'b0;
    logic       m_busy = 1'b0;
    int         m_lat = 0;
    logic [2:0] m_ch = 3'd0;
    int         rise_cnt = 0;
    int         avg_base = 0;
    logic       avg_mode = 1'b0;
    logic       hang_en = 1'b0;
    logic [2:0] hang_ch = 3'd0;

    always @(posedge clk) begin
        m_prev <= measure_start;
        if (!measure_start) begin
            m_busy       <= 1'b0;
            measure_done <= 1'b0;
        end else if (!m_prev) begin
            m_busy   <= 1'b1;
            m_lat    <= 0;
            m_ch     <= measure_ch;
            rise_cnt <= rise_cnt + 1;
        end else if (m_busy) begin
            m_lat <= m_lat + 1;
            if (m_lat == LAT - 1) begin
                m_busy <= 1'b0;
                if (!(hang_en && (m_ch == hang_ch))) begin
                    measure_done     <= 1'b1;
                    measure_dataread <= avg_mode ? 12'(rise_cnt - avg_base)
                                                 : (12'h100 + {9'b0, m_ch});
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: records channel at each start edge, counts scan_done pulses,
    // stamps the first timeout_err rise.
    // ------------------------------------------------------------------------
    logic [2:0] obs_q[$];
    int         cyc = 0;
    int         last_rise_cyc = 0;
    int         err_cyc = 0;
    int         done_pulses = 0;
    logic       mon_prev_start = 1'b0;
    logic       mon_prev_err = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (measure_start && !mon_prev_start) begin
            obs_q.push_back(measure_ch);
            last_rise_cyc = cyc;
        end
        mon_prev_start = measure_start;
        if ((timeout_err != 8'h00) && !mon_prev_err) begin
            err_cyc = cyc;
        end
        mon_prev_err = (timeout_err != 8'h00);
        if (scan_done === 1'b1) begin
            done_pulses = done_pulses + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] exp_q[$];
    int         obs_base = 0;
    int         done_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ch(input logic [2:0] ch, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ch);
    endtask

    task automatic begin_scoreboard();
        exp_q.delete();
        obs_base  = obs_q.size();
        done_base = done_pulses;
    endtask

    task automatic compare_obs(input string tag);
        int n_obs;
        n_obs = obs_q.size() - obs_base;
        check({tag, "_count"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            check({tag, "_ch"}, obs_q[obs_base + i], exp_q[i]);
        end
    endtask

    task automatic start_scan(input logic [7:0] m);
        ch_mask = m;
        scan_go = 1'b1;
        @(negedge clk);
        scan_go = 1'b0;
    endtask

    task automatic wait_scan_done(input string tag);
        int n;
        n = 0;
        while (scan_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, scan_done, 1);
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [11:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic bad;
        int   n;

        // Reset and idle
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (measure_start !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);
        check("rst_ch_valid", ch_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_measure_ch", measure_ch, 0);
        for (int i = 0; i < 8; i++) read_chk(3'(i), 12'h000, "rst_result");

        // Empty mask is ignored
        start_scan(8'h00);
        check("mask0_ignored", busy, 0);

        // Mask 0x05
        begin_scoreboard();
        push_ch(3'd0, N_CONV);
        push_ch(3'd2, N_CONV);
        start_scan(8'h05);
        check("go_busy", busy, 1);
        @(negedge clk);
        check("go_measure_ch", measure_ch, 0);
        check("go_start_low", measure_start, 0);
        wait_scan_done("scan05_done");
        check("scan05_busy_at_done", busy, 1);
        @(negedge clk);
        check("scan05_busy_fall", busy, 0);
        check("scan05_done_single", scan_done, 0);
        check("scan05_valid", ch_valid, 8'h05);
        compare_obs("scan05");
        read_chk(3'd0, 12'h100, "scan05_r0");
        read_chk(3'd2, 12'h102, "scan05_r2");
        read_chk(3'd1, 12'h000, "scan05_r1");
        check("scan05_pulses", done_pulses - done_base, 1);

        // Fill result[1] so the timeout test can prove it stays unchanged
        begin_scoreboard();
        push_ch(3'd1, N_CONV);
        start_scan(8'h02);
        wait_scan_done("scan02_done");
        @(negedge clk);
        read_chk(3'd1, 12'h101, "scan02_r1");

        // Timeout on channel 1
        hang_ch = 3'd1;
        hang_en = 1'b1;
        begin_scoreboard();
        push_ch(3'd0, N_CONV);
        push_ch(3'd1, 1);
        start_scan(8'h03);
        wait_scan_done("tmo_done");
        @(negedge clk);
        hang_en = 1'b0;
        check("tmo_err", timeout_err, 8'h02);
        check("tmo_valid", ch_valid, 8'h01);
        check("tmo_latency", err_cyc - last_rise_cyc, GUARD + TIMEOUT);
        compare_obs("tmo");
        read_chk(3'd1, 12'h101, "tmo_r1_kept");
        check("tmo_pulses", done_pulses - done_base, 1);

        // Continuous mode with a mask change mid-scan
        begin_scoreboard();
        push_ch(3'd7, N_CONV);
        scan_continuous = 1'b1;
        start_scan(8'h80);
        check("cont_err_cleared", timeout_err, 0);
        check("cont_valid_cleared", ch_valid, 0);
        repeat (20) @(negedge clk);
        ch_mask = 8'h01;
        wait_scan_done("cont_done1");
        check("cont_valid1", ch_valid, 8'h80);
        @(negedge clk);
        check("cont_busy_kept", busy, 1);
        check("cont_valid_relatch", ch_valid, 0);
        push_ch(3'd0, N_CONV);
        repeat (20) @(negedge clk);
        scan_continuous = 1'b0;
        wait_scan_done("cont_done2");
        check("cont_valid2", ch_valid, 8'h01);
        @(negedge clk);
        check("cont_idle", busy, 0);
        compare_obs("cont");
        read_chk(3'd7, 12'h107, "cont_r7");
        check("cont_pulses", done_pulses - done_base, 2);

        // Reset in the middle of WAIT
        start_scan(8'h01);
        n = 0;
        while (measure_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstw_reached_wait", measure_start, 1);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstw_start", measure_start, 0);
        check("rstw_busy", busy, 0);
        check("rstw_valid", ch_valid, 0);
        check("rstw_rd_data", rd_data, 0);
        reset_n = 1'b1;
        read_chk(3'd0, 12'h000, "rstw_r0_cleared");
        read_chk(3'd7, 12'h000, "rstw_r7_cleared");
        repeat (5) @(negedge clk);
        begin_scoreboard();
        push_ch(3'd2, N_CONV);
        start_scan(8'h04);
        wait_scan_done("rstw_scan_done");
        @(negedge clk);
        check("rstw_scan_valid", ch_valid, 8'h04);
        compare_obs("rstw");
        read_chk(3'd2, 12'h102, "rstw_r2");

`ifdef ADC_SCAN_AVG_EN
        // Averaging of 1,2,3,4 truncates to 2
        avg_base = rise_cnt;
        avg_mode = 1'b1;
        begin_scoreboard();
        push_ch(3'd0, 4);
        start_scan(8'h01);
        wait_scan_done("avg_done");
        @(negedge clk);
        avg_mode = 1'b0;
        compare_obs("avg");
        read_chk(3'd0, 12'h002, "avg_r0");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
